// File: rtl/pipeline_ctrl_pkg.sv
// Shared processor definitions: pipeline-control FSM encoding, stall counter
// width and the memory opcodes the hazard logic keys on.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    localparam int STALL_CNT_W = 16;

    localparam logic [4:0] OPC_LW = 5'b01000;
    localparam logic [4:0] OPC_SW = 5'b00111;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: arbitrates multdiv, taken-branch and
// load-use hazards and counts the cycles the PC is frozen.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_use_hazard,
    input  logic                   branch_taken,
    input  logic                   dx_is_multdiv,
    input  logic                   md_ready,
    input  logic                   md_exception,
    input  logic                   stall_cnt_clr,
    output logic                   pc_en,
    output logic                   fd_en,
    output logic                   dx_en,
    output logic                   fd_flush,
    output logic                   dx_flush,
    output logic                   xm_flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic                   md_exc_latched,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t state, state_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority in RUN: multdiv > taken branch > load-use. While reset is held
    // the pipeline free-runs with no start pulse.
    always_comb begin
        state_nxt = state;
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (dx_is_multdiv) begin
                        md_start  = 1'b1;
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_flush  = 1'b1;
                        state_nxt = ST_MD_WAIT;
                    end else if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (load_use_hazard) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        dx_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    // The completion cycle already advances the pipeline, so
                    // busy drops as soon as md_ready arrives.
                    if (md_ready) begin
                        state_nxt = ST_RUN;
                    end else begin
                        md_busy  = 1'b1;
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        dx_en    = 1'b0;
                        xm_flush = 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_exc_latched <= 1'b0;
        end else if ((state == ST_MD_WAIT) && md_ready && md_exception) begin
            md_exc_latched <= 1'b1;
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (stall_cnt_clr),
        .inc   (~pc_en),
        .count (stall_cnt)
    );

endmodule
